clm_rand_source: RTL

// - Upstream feeder for the masked-state refresh stage: supplies one fresh red_poly_t randomness word r per accepted

---
 rtl/clm_rand_source_pkg.sv | 23 ++
 rtl/clm_rand_source_lfsr_step.sv | 25 ++
 rtl/clm_rand_source.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/clm_rand_source_pkg.sv
// Shared types and constants for the randomness source.
// The LFSR is a right-shifting Fibonacci form of x^64+x^63+x^61+x^60+1.
package clm_rand_source_pkg;

  localparam int D      = 1;
  localparam int COEF_W = 16;

  typedef logic [(D+1)*COEF_W-1:0] red_poly_t;

  localparam int RW     = $bits(red_poly_t);
  localparam int LFSR_W = 64;

  // bit0..bit4 taps correspond to x^64, x^63, x^61, x^60
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 64'h0000_0000_0000_001B;
  localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 64'h9E37_79B9_7F4A_7C15;

  typedef enum logic [1:0] {
    ST_UNSEEDED,
    ST_WARMUP,
    ST_RUN
  } rand_fsm_t;

endpackage

// File: rtl/clm_rand_source_lfsr_step.sv
// N combinational LFSR steps; first shifted-out bit lands in bits_o[0].
// Pure function of the current state, no storage.
module clm_lfsr_step
  import clm_rand_source_pkg::*;
#(
  parameter int N = RW
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [N-1:0]      bits_o
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s      = state_i;
    bits_o = '0;
    for (int i = 0; i < N; i++) begin
      bits_o[i] = s[0];
      s         = {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    end
    state_o = s;
  end

endmodule

// File: rtl/clm_rand_source.sv
// Seeded LFSR randomness feeder with warm-up discard, 2-deep output
// buffer, valid/ready delivery and a sticky reseed request.
module clm_rand_source
  import clm_rand_source_pkg::*;
#(
  parameter int d          = D,
  parameter int WARMUP     = 4,
  parameter int RESEED_INT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     seed_valid,
  input  logic [LFSR_W-1:0]        seed,
  output logic                     seed_ready,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic [(d+1)*COEF_W-1:0]  r,
  output logic                     reseed_req
);

  localparam int RWL = (d+1)*COEF_W;
  localparam int WCW = $clog2(WARMUP + 2);
  localparam int CW  = $clog2(RESEED_INT + 2);

  localparam logic [WCW-1:0] WLAST =
    WCW'(WARMUP > 0 ? WARMUP - 1 : 0);
  localparam logic [CW-1:0]  CMAX  = CW'(RESEED_INT);

  rand_fsm_t         state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [CW-1:0]     wc_q, wc_d;
  logic              req_q, req_d;
  logic [RWL-1:0]    slot0_q, slot0_d;
  logic [RWL-1:0]    slot1_q, slot1_d;
  logic [1:0]        fcnt_q, fcnt_d;

  logic [LFSR_W-1:0] lfsr_nxt;
  logic [RWL-1:0]    word;
  logic              seed_load;
  logic              pop;
  logic              push;

  clm_lfsr_step #(.N(RWL)) u_step (
    .state_i (lfsr_q),
    .state_o (lfsr_nxt),
    .bits_o  (word)
  );

  assign seed_ready = 1'b1;
  assign seed_load  = seed_valid;
  assign r_valid    = (fcnt_q != 2'd0);
  assign r          = r_valid ? slot0_q : '0;
  assign reseed_req = req_q;

  // seed load pre-empts any transfer in the same cycle
  assign pop  = r_valid & r_ready & ~seed_load;
  assign push = (state_q == ST_RUN) & ((fcnt_q != 2'd2) | pop)
              & ~seed_load;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    wcnt_d  = wcnt_q;
    wc_d    = wc_q;
    req_d   = req_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    fcnt_d  = fcnt_q;

    if (seed_load) begin
      lfsr_d  = (seed == '0) ? LFSR_ZERO_SUB : seed;
      state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      wcnt_d  = '0;
      wc_d    = '0;
      req_d   = 1'b0;
      slot0_d = '0;
      slot1_d = '0;
      fcnt_d  = 2'd0;
    end else begin
      unique case (state_q)
        ST_UNSEEDED: ;
        ST_WARMUP: begin
          lfsr_d = lfsr_nxt;
          wcnt_d = wcnt_q + WCW'(1);
          if (wcnt_q == WLAST) state_d = ST_RUN;
        end
        ST_RUN: if (push) lfsr_d = lfsr_nxt;
        default: state_d = ST_UNSEEDED;
      endcase

      unique case (1'b1)
        push & ~pop: begin
          if (fcnt_q == 2'd0) slot0_d = word;
          else                slot1_d = word;
          fcnt_d = fcnt_q + 2'd1;
        end
        pop & ~push: begin
          slot0_d = slot1_q;
          fcnt_d  = fcnt_q - 2'd1;
        end
        push & pop: begin
          if (fcnt_q == 2'd1) begin
            slot0_d = word;
          end else begin
            slot0_d = slot1_q;
            slot1_d = word;
          end
        end
        default: ;
      endcase

      if (pop && wc_q != CMAX) wc_d = wc_q + CW'(1);
      if (RESEED_INT != 0 && wc_d == CMAX) req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNSEEDED;
      lfsr_q  <= '0;
      wcnt_q  <= '0;
      wc_q    <= '0;
      req_q   <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      wcnt_q  <= wcnt_d;
      wc_q    <= wc_d;
      req_q   <= req_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule
